// File: rtl/rob_flush_ctrl.sv
// Misprediction flush sequencer: waits for committed stores to drain, holds the
// pipeline flush for FLUSH_CYCLES cycles, then issues a one-cycle PC redirect.
module rob_flush_ctrl #(
  parameter int CNT_W        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_req_from_ro_buffer,
  input  logic [31:0] flush_pc_from_ro_buffer,
  input  logic        store_commit_from_ro_buffer,
  input  logic        store_done_from_ls_buffer,
  output logic        stall_to_ro_buffer,
  output logic        flush_out,
  output logic [31:0] pc_out,
  output logic        pc_valid_out,
  output logic        err_out
);

  localparam int TIMER_W = 4;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic               err_reg;
  logic               err_next;
  logic [TIMER_W-1:0] timer_reg;
  logic [31:0]        pc_reg;
  logic               stall_reg;
  logic               flush_reg;
  logic               pc_valid_reg;

  // Outstanding-store counter: saturates at both ends and flags the misuse.
  always_comb begin
    cnt_next = cnt_reg;
    err_next = err_reg;
    if (store_commit_from_ro_buffer && !store_done_from_ls_buffer) begin
      if (cnt_reg == CNT_MAX) begin
        err_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else if (store_done_from_ls_buffer && !store_commit_from_ro_buffer) begin
      if (cnt_reg == '0) begin
        err_next = 1'b1;
      end else begin
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      timer_reg    <= '0;
      pc_reg       <= '0;
      stall_reg    <= 1'b0;
      flush_reg    <= 1'b0;
      pc_valid_reg <= 1'b0;
    end else if (rdy_in) begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
      case (state_reg)
        IDLE: begin
          if (flush_req_from_ro_buffer) begin
            pc_reg    <= flush_pc_from_ro_buffer;
            stall_reg <= 1'b1;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          // Registered count: a commit arriving with the request still holds us here.
          if (cnt_reg == '0) begin
            timer_reg <= TIMER_LOAD;
            flush_reg <= 1'b1;
            state_reg <= FLUSH;
          end
        end
        FLUSH: begin
          if (timer_reg == '0) begin
            flush_reg    <= 1'b0;
            pc_valid_reg <= 1'b1;
            state_reg    <= REDIRECT;
          end else begin
            timer_reg <= timer_reg - TIMER_W'(1);
          end
        end
        REDIRECT: begin
          pc_valid_reg <= 1'b0;
          stall_reg    <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          stall_reg    <= 1'b0;
          flush_reg    <= 1'b0;
          pc_valid_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  assign stall_to_ro_buffer = stall_reg;
  assign flush_out          = flush_reg;
  assign pc_out             = pc_reg;
  assign pc_valid_out       = pc_valid_reg;
  assign err_out            = err_reg;

endmodule

// File: tb/tb_rob_flush_ctrl.sv
// Scenario bench for rob_flush_ctrl: per-cycle timeline checks in each task, plus a
// scoreboard of expected redirects (pc and flush width) checked on each pc_valid_out.
module tb_rob_flush_ctrl;

  localparam int CNT_W = 2;
  localparam int FC    = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        req = 1'b0;
  logic [31:0] fpc = '0;
  logic        commit = 1'b0;
  logic        done = 1'b0;
  logic        stall;
  logic        flush;
  logic [31:0] pc_out;
  logic        pcv;
  logic        err;

  rob_flush_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FC)) dut (
    .clk_in                      (clk_in),
    .rst_in                      (rst_in),
    .rdy_in                      (rdy_in),
    .flush_req_from_ro_buffer    (req),
    .flush_pc_from_ro_buffer     (fpc),
    .store_commit_from_ro_buffer (commit),
    .store_done_from_ls_buffer   (done),
    .stall_to_ro_buffer          (stall),
    .flush_out                   (flush),
    .pc_out                      (pc_out),
    .pc_valid_out                (pcv),
    .err_out                     (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    int          flen;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   flush_run = 0;
  logic prev_pcv = 1'b0;

  // Redirect monitor: measures flush width and pops the expected redirect.
  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in) begin
      flush_run = 0;
      prev_pcv  = 1'b0;
    end else begin
      if (flush) flush_run++;
      if (pcv && !prev_pcv) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_redirect got pc=%h want none", pc_out);
        end else begin
          e = sb.pop_front();
          if (pc_out !== e.pc || flush_run !== e.flen) begin
            bad++;
            $display("FAIL sb_redirect got pc=%h flush_len=%0d want pc=%h flush_len=%0d",
                     pc_out, flush_run, e.pc, e.flen);
          end else begin
            $display("redirect pc=%h flush_len=%0d ok", pc_out, flush_run);
          end
        end
        flush_run = 0;
      end
      prev_pcv = pcv;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    repeat (2) tick();
    total++;
    if ({stall, flush, pcv, err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {stall, flush, pcv, err});
    end
    total++;
    if (pc_out !== 32'h0) begin
      bad++;
      $display("FAIL reset_pc got=%h want=0", pc_out);
    end
    rst_in = 1'b1;
    tick();
    total++;
    if ({stall, flush, pcv, err} !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=0000", {stall, flush, pcv, err});
    end
    $display("reset checked");
  endtask

  task automatic test_basic_flush();
    logic [2:0] tl [5] = '{3'b100, 3'b110, 3'b110, 3'b101, 3'b000};
    fpc = 32'h0000_1000;
    req = 1'b1;
    sb.push_back('{32'h0000_1000, FC});
    tick();
    req = 1'b0;
    fpc = '0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      total++;
      if ({stall, flush, pcv} !== tl[k]) begin
        bad++;
        $display("FAIL basic_T+%0d got=%b want=%b", k + 1, {stall, flush, pcv}, tl[k]);
      end
      if (k >= 3) begin
        total++;
        if (pc_out !== 32'h0000_1000) begin
          bad++;
          $display("FAIL basic_pc_T+%0d got=%h want=00001000", k + 1, pc_out);
        end
      end
    end
    $display("basic flush checked");
  endtask

  task automatic test_drain_wait();
    logic [2:0] want;
    int n;
    for (int i = 0; i < 3; i++) begin
      commit = 1'b1;
      tick();
    end
    commit = 1'b0;
    sb.push_back('{32'h0000_1100, FC});
    for (int c = 0; c < 12; c++) begin
      req  = (c == 0);
      fpc  = (c == 0) ? 32'h0000_1100 : 32'h0;
      done = (c == 2 || c == 4 || c == 6);
      tick();
      n = c + 1;
      want = {(n >= 1 && n <= 10), (n == 8 || n == 9), (n == 10)};
      total++;
      if ({stall, flush, pcv} !== want) begin
        bad++;
        $display("FAIL drain_T+%0d got=%b want=%b", n, {stall, flush, pcv}, want);
      end
    end
    req = 1'b0;
    done = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL drain_err got=%b want=0", err);
    end
    $display("drain wait checked");
  endtask

  task automatic test_commit_with_req();
    logic [2:0] want;
    int n;
    sb.push_back('{32'h0000_2000, FC});
    for (int c = 0; c < 9; c++) begin
      req    = (c == 0 || c == 5);
      commit = (c == 0);
      done   = (c == 3);
      fpc    = (c == 0) ? 32'h0000_2000 : ((c == 5) ? 32'hDEAD_BEEF : 32'h0);
      tick();
      n = c + 1;
      want = {(n >= 1 && n <= 7), (n == 5 || n == 6), (n == 7)};
      total++;
      if ({stall, flush, pcv} !== want) begin
        bad++;
        $display("FAIL cwr_T+%0d got=%b want=%b", n, {stall, flush, pcv}, want);
      end
    end
    req = 1'b0;
    commit = 1'b0;
    done = 1'b0;
    fpc = '0;
    total++;
    if (pc_out !== 32'h0000_2000) begin
      bad++;
      $display("FAIL cwr_pc_held got=%h want=00002000", pc_out);
    end
    $display("commit with request checked");
  endtask

  task automatic test_counter_bounds();
    for (int i = 0; i < 4; i++) begin
      commit = 1'b1;
      tick();
    end
    commit = 1'b0;
    total++;
    if (dut.cnt_reg !== 2'd3 || err !== 1'b1) begin
      bad++;
      $display("FAIL cnt_overflow got cnt=%0d err=%b want cnt=3 err=1", dut.cnt_reg, err);
    end
    #2 rst_in = 1'b0;
    #1;
    total++;
    if (dut.cnt_reg !== 2'd0 || err !== 1'b0) begin
      bad++;
      $display("FAIL cnt_reset got cnt=%0d err=%b want cnt=0 err=0", dut.cnt_reg, err);
    end
    tick();
    rst_in = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (dut.cnt_reg !== 2'd0 || err !== 1'b1) begin
      bad++;
      $display("FAIL cnt_underflow got cnt=%0d err=%b want cnt=0 err=1", dut.cnt_reg, err);
    end
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    commit = 1'b1;
    tick();
    done = 1'b1;
    tick();
    commit = 1'b0;
    done = 1'b0;
    total++;
    if (dut.cnt_reg !== 2'd1 || err !== 1'b0) begin
      bad++;
      $display("FAIL cnt_both got cnt=%0d err=%b want cnt=1 err=0", dut.cnt_reg, err);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++;
    if (dut.cnt_reg !== 2'd0) begin
      bad++;
      $display("FAIL cnt_dec got cnt=%0d want 0", dut.cnt_reg);
    end
    $display("counter bounds checked");
  endtask

  task automatic test_rdy_stall();
    logic [2:0] want;
    int n;
    sb.push_back('{32'h0000_3000, FC + 3});
    for (int c = 0; c < 8; c++) begin
      req    = (c == 0);
      fpc    = (c == 0) ? 32'h0000_3000 : 32'h0;
      rdy_in = !(c >= 2 && c <= 4);
      commit = (c == 3);
      tick();
      n = c + 1;
      want = {(n >= 1 && n <= 7), (n >= 2 && n <= 6), (n == 7)};
      total++;
      if ({stall, flush, pcv} !== want) begin
        bad++;
        $display("FAIL rdy_T+%0d got=%b want=%b", n, {stall, flush, pcv}, want);
      end
    end
    req = 1'b0;
    commit = 1'b0;
    rdy_in = 1'b1;
    total++;
    if (dut.cnt_reg !== 2'd0) begin
      bad++;
      $display("FAIL rdy_commit_dropped got cnt=%0d want 0", dut.cnt_reg);
    end
    $display("rdy stall checked");
  endtask

  task automatic test_back_to_back();
    logic [2:0] want;
    int n;
    sb.push_back('{32'h0000_4000, FC});
    sb.push_back('{32'h0000_5000, FC});
    for (int c = 0; c < 10; c++) begin
      req = (c == 0 || c == 5);
      fpc = (c == 0) ? 32'h0000_4000 : ((c == 5) ? 32'h0000_5000 : 32'h0);
      tick();
      n = c + 1;
      want = {((n >= 1 && n <= 4) || (n >= 6 && n <= 9)),
              (n == 2 || n == 3 || n == 7 || n == 8), (n == 4 || n == 9)};
      total++;
      if ({stall, flush, pcv} !== want) begin
        bad++;
        $display("FAIL b2b_T+%0d got=%b want=%b", n, {stall, flush, pcv}, want);
      end
    end
    req = 1'b0;
    fpc = '0;
    total++;
    if (pc_out !== 32'h0000_5000) begin
      bad++;
      $display("FAIL b2b_pc got=%h want=00005000", pc_out);
    end
    $display("back to back checked");
  endtask

  task automatic test_reset_mid_flush();
    logic [2:0] want;
    int n;
    for (int c = 0; c < 3; c++) begin
      req    = (c == 0);
      fpc    = (c == 0) ? 32'h0000_5500 : 32'h0;
      commit = (c == 1 || c == 2);
      tick();
    end
    req = 1'b0;
    commit = 1'b0;
    total++;
    if (flush !== 1'b1 || dut.cnt_reg !== 2'd2) begin
      bad++;
      $display("FAIL rmf_setup got flush=%b cnt=%0d want flush=1 cnt=2", flush, dut.cnt_reg);
    end
    #2 rst_in = 1'b0;
    #1;
    total++;
    if ({stall, flush, pcv, err} !== 4'b0000 || pc_out !== 32'h0 || dut.cnt_reg !== 2'd0) begin
      bad++;
      $display("FAIL rmf_async got flags=%b pc=%h cnt=%0d want 0000 0 0",
               {stall, flush, pcv, err}, pc_out, dut.cnt_reg);
    end
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    sb.push_back('{32'h0000_6000, FC});
    for (int c = 0; c < 5; c++) begin
      req = (c == 0);
      fpc = (c == 0) ? 32'h0000_6000 : 32'h0;
      tick();
      n = c + 1;
      want = {(n >= 1 && n <= 4), (n == 2 || n == 3), (n == 4)};
      total++;
      if ({stall, flush, pcv} !== want) begin
        bad++;
        $display("FAIL rmf_fresh_T+%0d got=%b want=%b", n, {stall, flush, pcv}, want);
      end
    end
    req = 1'b0;
    fpc = '0;
    $display("reset mid flush checked");
  endtask

  initial begin
    test_reset();
    test_basic_flush();
    test_drain_wait();
    test_commit_with_req();
    test_counter_bounds();
    test_rdy_stall();
    test_back_to_back();
    test_reset_mid_flush();
    tick();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rob_flush_ctrl.md
# rob_flush_ctrl

Sequences the misprediction flush that the reorder buffer broadcasts over the ROB bus. It tracks committed-but-unwritten stores, holds the flush until the load/store buffer has drained them, then drives the pipeline-wide flush for a fixed number of cycles and issues a one-cycle PC redirect to the instruction fetcher. It sits between the reorder buffer (request side) and the ROB bus (`flush_out`/`pc_out` feed the bus's reset/PC inputs), and it stalls ROB commit while a flush is in progress.

## Interface
- `CNT_W`, default 4: width of the outstanding-store counter; maximum count is 2^CNT_W−1.
- `FLUSH_CYCLES`, default 2: number of cycles `flush_out` is held high; legal range 1..16.

- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global ready; when low, all state is frozen and all inputs are ignored.
- `flush_req_from_ro_buffer`  in  1  one-cycle request for a misprediction flush.
- `flush_pc_from_ro_buffer`  in  32  redirect target, sampled with the request.
- `store_commit_from_ro_buffer`  in  1  pulse: one store was committed.
- `store_done_from_ls_buffer`  in  1  pulse: one committed store was written to memory.
- `stall_to_ro_buffer`  out  1  high whenever the controller is not IDLE.
- `flush_out`  out  1  flush, high while in FLUSH.
- `pc_out`  out  32  latched redirect target.
- `pc_valid_out`  out  1  high for the single REDIRECT cycle.
- `err_out`  out  1  sticky counter over/underflow flag.

## Operation
- State register values: IDLE=0, DRAIN=1, FLUSH=2, REDIRECT=3. Outputs are decoded from registers only; there are no combinational input-to-output paths.
- Counter `cnt` (CNT_W bits) updates in every state:
  - +1 on commit only.
  - −1 on done only.
  - unchanged when both or neither occur.
- Commit while `cnt` is at its maximum: `cnt` saturates and `err_out` is set.
- Done while `cnt`=0: `cnt` stays 0 and `err_out` is set.
- `err_out` clears only on reset.
- IDLE: on `flush_req`, latch `flush_pc` into `pc_out` and go to DRAIN.
- DRAIN: when `cnt`=0 (the registered value), load `timer`=FLUSH_CYCLES−1 and go to FLUSH.
- FLUSH: `flush_out`=1. If `timer`=0, go to REDIRECT; otherwise decrement `timer`.
- REDIRECT: `pc_valid_out`=1, then go to IDLE.
- `flush_req` outside IDLE is ignored; `pc_out` is not overwritten.
- A commit in the same cycle as `flush_req` is counted, so DRAIN waits for that store too.
- `pc_out` holds its value between flushes.
- `rdy_in`=0: state, `cnt`, `timer`, `pc_out` and `err_out` all hold, and input pulses in that cycle are dropped.
- Reset, including mid-flush, forces:
  - state=IDLE, `cnt`=0, `timer`=0;
  - `pc_out`=0, `err_out`=0, `flush_out`=0, `pc_valid_out`=0, `stall_to_ro_buffer`=0.
- Reset mid-flush does not complete the aborted flush.

## Timing
- Request at cycle T with `cnt`=0 and no store events:
  - T+1: DRAIN.
  - T+2 .. T+1+FLUSH_CYCLES: FLUSH, `flush_out` high.
  - T+2+FLUSH_CYCLES: REDIRECT, `pc_valid_out` high.
  - T+3+FLUSH_CYCLES: IDLE.
- `stall_to_ro_buffer` is high from T+1 through T+2+FLUSH_CYCLES.
- Minimum flush-to-idle latency is FLUSH_CYCLES+3 cycles.
- Each cycle spent in DRAIN with `cnt`≠0 adds one cycle.
- A done pulse at cycle D that brings `cnt` to 0 gives FLUSH at D+2. `cnt` reads 0 at D+1, and DRAIN exits on that edge.
- A new request is accepted in the first IDLE cycle, T+3+FLUSH_CYCLES.
- Each `rdy_in`-low cycle stretches every phase by exactly one cycle.

## Test plan
- Basic flush (FLUSH_CYCLES=2, `cnt`=0): request with pc=0x0000_1000 at T → `flush_out` high at T+2 and T+3; `pc_valid_out` high at T+4 with `pc_out`=0x1000; stall high T+1..T+4.
- Drain wait: 3 commits, then a request, then done pulses spaced 2 cycles apart → `flush_out` rises exactly 2 cycles after the third done; `cnt` never goes negative.
- Commit with request, plus mid-flush request: commit and request in the same cycle → one done is required before FLUSH. A second request during FLUSH with pc=0xDEAD_BEEF → ignored; `pc_out` unchanged.
- Counter bounds (CNT_W=2): 4 commits → `cnt`=3, `err_out`=1. Reset, then a done at `cnt`=0 → `err_out`=1, `cnt`=0. Simultaneous commit and done at `cnt`=1 → `cnt`=1.
- rdy stall: drop `rdy_in` for 3 cycles during FLUSH → `flush_out` width becomes FLUSH_CYCLES+3; a commit pulse during `rdy_in`=0 is not counted.
- Reset mid-operation: assert `rst_in` low asynchronously while in FLUSH with `cnt`=2 → all outputs 0 immediately. After release, a fresh request completes in FLUSH_CYCLES+3 cycles.
